// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster pixel stream into vertically aligned
// column taps (two lines ago, one line ago, current) for a 3x3 window stage.
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 320,
    parameter int PIC_HEIGHT = 240,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sof,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eol
);

    localparam int AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(PIC_HEIGHT - 1);
    localparam logic [CNT_W-1:0] FIRST_VALID_ROW = CNT_W'(2);

    logic [WIDTH-1:0] line_a [PIC_WIDTH];
    logic [WIDTH-1:0] line_b [PIC_WIDTH];

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col_e;
    logic [CNT_W-1:0] row_e;
    logic [AW-1:0]    addr_p0;
    logic             primed_p0;
    logic             last_col_p0;

    logic             vld_p1;
    logic             eol_p1;
    logic [WIDTH-1:0] dout1_p1;
    logic [WIDTH-1:0] dout2_p1;
    logic [WIDTH-1:0] dout3_p1;

    // Stage 0: effective position; sof re-aligns without dropping the pixel
    always_comb begin
        col_e       = (valid_in && sof) ? '0 : col;
        row_e       = (valid_in && sof) ? '0 : row;
        addr_p0     = col_e[AW-1:0];
        primed_p0   = (row_e >= FIRST_VALID_ROW);
        last_col_p0 = (col_e == LAST_COL);
    end

    // Line memories shift by one line per write; no reset so they map to RAM
    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            line_b[addr_p0] <= din;
            line_a[addr_p0] <= line_b[addr_p0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (last_col_p0) begin
                col <= '0;
                row <= (row_e == LAST_ROW) ? '0 : row_e + CNT_W'(1);
            end else begin
                col <= col_e + CNT_W'(1);
                row <= row_e;
            end
        end
    end

    // Stage 1: registered taps; data holds across input gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            eol_p1   <= 1'b0;
            dout1_p1 <= '0;
            dout2_p1 <= '0;
            dout3_p1 <= '0;
        end else if (valid_in) begin
            vld_p1   <= primed_p0;
            eol_p1   <= primed_p0 && last_col_p0;
            dout1_p1 <= line_a[addr_p0];
            dout2_p1 <= line_b[addr_p0];
            dout3_p1 <= din;
        end else begin
            vld_p1 <= 1'b0;
            eol_p1 <= 1'b0;
        end
    end

    assign valid_out = vld_p1;
    assign eol       = eol_p1;
    assign dout1     = dout1_p1;
    assign dout2     = dout2_p1;
    assign dout3     = dout3_p1;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row on a 4x4 picture: a vector table for reset and
// the first frame, scenario sequences, then random traffic against a model.
module tb_line_buffer_3row;

    localparam int W  = 24;
    localparam int PW = 4;
    localparam int PH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          sof;
    logic [W-1:0]  din;
    logic          valid_out;
    logic [W-1:0]  dout1;
    logic [W-1:0]  dout2;
    logic [W-1:0]  dout3;
    logic          eol;

    line_buffer_3row #(
        .WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sof(sof), .din(din),
        .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .eol(eol)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int vcnt;
    int ecnt;

    // Reference model: position plus a picture of every pixel stored this frame
    int           mr;
    int           mc;
    logic [W-1:0] hist [PH][PW];
    logic         ev;
    logic         ee;
    logic [W-1:0] ed1;
    logic [W-1:0] ed2;
    logic [W-1:0] ed3;
    logic         k12;

    typedef struct {
        logic         r;
        logic         v;
        logic         s;
        logic [W-1:0] d;
        logic         ev;
        logic         ee;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [W-1:0] e3;
        logic         c12;
    } vec_t;

    vec_t tbl [1 + PW*PH];

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        int re;
        int ce;
        rst = r; valid_in = v; sof = s; din = d;
        if (r) begin
            mr = 0; mc = 0; ev = 0; ee = 0;
            ed1 = '0; ed2 = '0; ed3 = '0; k12 = 1'b1;
        end else if (v) begin
            re  = s ? 0 : mr;
            ce  = s ? 0 : mc;
            ev  = (re >= 2);
            ee  = (re >= 2) && (ce == PW-1);
            ed3 = d;
            if (re >= 2) begin
                ed1 = hist[re-2][ce];
                ed2 = hist[re-1][ce];
            end
            k12 = (re >= 2);
            hist[re][ce] = d;
            if (ce == PW-1) begin
                mc = 0;
                mr = (re == PH-1) ? 0 : re + 1;
            end else begin
                mc = ce + 1;
                mr = re;
            end
        end else begin
            ev = 1'b0;
            ee = 1'b0;
        end
        @(posedge clk);
        #1;
        if (valid_out === 1'b1) vcnt++;
        if (eol === 1'b1) ecnt++;
    endtask

    task automatic check_model();
        cmp("valid_out", W'(valid_out), W'(ev));
        cmp("eol", W'(eol), W'(ee));
        cmp("dout3", dout3, ed3);
        if (k12) begin
            cmp("dout1", dout1, ed1);
            cmp("dout2", dout2, ed2);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        apply(r, v, s, d);
        check_model();
    endtask

    task automatic run_frame(input bit with_sof, input bit gaps, input bit use_fixed,
                             input logic [W-1:0] fixed_v);
        logic [W-1:0] px;
        vcnt = 0;
        ecnt = 0;
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                px = use_fixed ? fixed_v : W'(16*r + c);
                step(1'b0, 1'b1, with_sof && r == 0 && c == 0, px);
                if (!use_fixed && r == 2 && c == 0) begin
                    cmp("first col dout1", dout1, 24'h000000);
                    cmp("first col dout2", dout2, 24'h000010);
                    cmp("first col dout3", dout3, 24'h000020);
                end
                if (!use_fixed && r == PH-1 && c == PW-1) begin
                    cmp("last col dout1", dout1, 24'h000013);
                    cmp("last col dout2", dout2, 24'h000023);
                    cmp("last col dout3", dout3, 24'h000033);
                    cmp("last col eol", W'(eol), W'(1));
                end
                if (gaps) step(1'b0, 1'b0, 1'b0, W'($urandom));
            end
        end
        cmp("frame valid count", W'(vcnt), W'((PH-2)*PW));
        cmp("frame eol count", W'(ecnt), W'(PH-2));
    endtask

    initial begin
        logic [W-1:0] d;
        int           k;
        rst = 1'b0; valid_in = 1'b0; sof = 1'b0; din = '0;
        vcnt = 0; ecnt = 0;

        // Table: reset vector, then a continuous frame with sof on the first pixel
        tbl[0] = '{r:1'b1, v:1'b1, s:1'b0, d:24'hABCDEF, ev:1'b0, ee:1'b0,
                   e1:'0, e2:'0, e3:'0, c12:1'b1};
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                k = 1 + r*PW + c;
                tbl[k].r   = 1'b0;
                tbl[k].v   = 1'b1;
                tbl[k].s   = (r == 0 && c == 0);
                tbl[k].d   = W'(16*r + c);
                tbl[k].ev  = (r >= 2);
                tbl[k].ee  = (r >= 2) && (c == PW-1);
                tbl[k].e3  = W'(16*r + c);
                tbl[k].e1  = (r >= 2) ? W'(16*(r-2) + c) : '0;
                tbl[k].e2  = (r >= 2) ? W'(16*(r-1) + c) : '0;
                tbl[k].c12 = (r >= 2);
            end
        end

        @(negedge clk);
        vcnt = 0;
        ecnt = 0;
        for (int i = 0; i < 1 + PW*PH; i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
            cmp($sformatf("tbl[%0d] valid_out", i), W'(valid_out), W'(tbl[i].ev));
            cmp($sformatf("tbl[%0d] eol", i), W'(eol), W'(tbl[i].ee));
            cmp($sformatf("tbl[%0d] dout3", i), dout3, tbl[i].e3);
            if (tbl[i].c12) begin
                cmp($sformatf("tbl[%0d] dout1", i), dout1, tbl[i].e1);
                cmp($sformatf("tbl[%0d] dout2", i), dout2, tbl[i].e2);
            end
        end
        cmp("tbl valid count", W'(vcnt), W'(8));
        cmp("tbl eol count", W'(ecnt), W'(2));

        // Every-other-cycle input
        run_frame(1'b1, 1'b1, 1'b0, '0);

        // Two frames back-to-back without sof
        run_frame(1'b0, 1'b0, 1'b0, '0);
        run_frame(1'b0, 1'b0, 1'b0, '0);

        // sof on pixel (1,2): the next 8 accepted pixels must not be valid
        for (int i = 0; i < PW + 2; i++) step(1'b0, 1'b1, 1'b0, W'(16*(i/PW) + i%PW));
        vcnt = 0;
        for (int i = 0; i < 2*PW*PH; i++) begin
            step(1'b0, 1'b1, i == 0, W'(24'h12 + i));
            if (i == 2*PW - 1) cmp("post-sof valid count", W'(vcnt), W'(0));
        end

        // Reset during row 3 with a pixel presented, then a clean frame
        for (int i = 0; i < 3*PW + 2; i++) step(1'b0, 1'b1, 1'b0, W'(16*(i/PW) + i%PW));
        step(1'b1, 1'b1, 1'b0, 24'h777777);
        cmp("rst valid_out", W'(valid_out), W'(0));
        cmp("rst eol", W'(eol), W'(0));
        cmp("rst dout1", dout1, '0);
        cmp("rst dout2", dout2, '0);
        cmp("rst dout3", dout3, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        run_frame(1'b0, 1'b0, 1'b0, '0);

        // All-ones frame then all-zeros frame
        run_frame(1'b1, 1'b0, 1'b1, 24'hFFFFFF);
        run_frame(1'b0, 1'b0, 1'b1, 24'h000000);

        // Random traffic with occasional sof and reset
        for (int i = 0; i < 4000; i++) begin
            d = W'($urandom);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
- Producer side of the 3x3 window interface: takes a raster pixel stream and presents three vertically aligned row taps (two lines ago, one line ago, current) with a qualifying valid.
- Sits between the pixel source and the 3x3 window/kernel stage.
- Its dout1/dout2/dout3/valid_out drive that stage's din1/din2/din3/valid_in directly.
- Holds two full lines in internal memories and suppresses valid until two lines of the current frame are stored.

Parameters:
- WIDTH, 24, pixel width in bits ({R,G,B}, 8 bits each).
- PIC_WIDTH, 320, pixels per line.
- PIC_HEIGHT, 240, lines per frame.
- CNT_W, 10, width of the column and row counters; must satisfy 2^CNT_W > max(PIC_WIDTH, PIC_HEIGHT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  din is a valid pixel this cycle.
- sof  input  1  start of frame; sampled only when valid_in=1.
- din  input  WIDTH  pixel, raster order.
- valid_out  output  1  dout1..dout3 hold one aligned column.
- dout1  output  WIDTH  pixel at same column, two lines earlier.
- dout2  output  WIDTH  pixel at same column, one line earlier.
- dout3  output  WIDTH  current pixel (din delayed one cycle).
- eol  output  1  qualifies valid_out on the last column of a line.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. No other control inputs.
- Reset (rst=1 at an edge), taking priority over everything:
  - col=0, row=0.
  - valid_out=0, eol=0, dout1=dout2=dout3=0.
  - Line memories are not cleared; valid gating makes their contents don't-care.
- Effective position on an accepted pixel:
  - If valid_in=1 and sof=1: use col_e=0, row_e=0.
  - Otherwise: use col_e=col, row_e=row.
  - So sof re-aligns to row 0 col 0 without losing the pixel.
- On valid_in=1, one edge performs:
  - Memories, read-before-write at address col_e: lineB[col_e] <= din; lineA[col_e] <= old lineB[col_e].
  - Outputs: dout3 <= din; dout2 <= old lineB[col_e]; dout1 <= old lineA[col_e].
  - valid_out <= (row_e >= 2).
  - eol <= (row_e >= 2) && (col_e == PIC_WIDTH-1).
  - If col_e == PIC_WIDTH-1: col <= 0, and row <= (row_e == PIC_HEIGHT-1) ? 0 : row_e+1.
  - Otherwise: col <= col_e+1, row <= row_e.
- On valid_in=0:
  - valid_out <= 0, eol <= 0.
  - Counters, memories and dout1..3 hold.
- Latency: exactly 1 cycle from an accepted din to its dout3/valid_out.
- Throughput: one pixel per clock; arbitrary gaps in valid_in are allowed.
- Priming: per frame, the first 2*PIC_WIDTH accepted pixels produce no valid_out. Each frame then produces (PIC_HEIGHT-2)*PIC_WIDTH valid_out pulses.
- Frame wrap: after pixel (PIC_HEIGHT-1, PIC_WIDTH-1), row returns to 0 and priming restarts. Rows from the previous frame are never paired with the new frame.
- sof when already at row 0 col 0: no effect beyond normal operation.
- Reset mid-line: the next accepted pixel is row 0 col 0; stale memory contents are never emitted.
- Width: memories are WIDTH bits × PIC_WIDTH entries each. No arithmetic is applied to pixel data; the data path is bit-exact.

Test Plan:
- All scenarios use PIC_WIDTH=4, PIC_HEIGHT=4 and din = 16*r + c for row r, column c.
1. Continuous 4x4 frame, sof on the first pixel:
   - 8 valid_out pulses, the first on the cycle after pixel (2,0).
   - First column: dout1=0x00, dout2=0x10, dout3=0x20.
   - Last column: dout1=0x13, dout2=0x23, dout3=0x33, with eol=1.
   - eol pulses exactly twice.
2. Same frame with valid_in high only every other cycle:
   - Identical valid_out data sequence.
   - valid_out=0 during gaps, and dout values hold their last value.
3. Two frames back-to-back without sof:
   - Frame 2 pixels (0,x) and (1,x) give no valid_out.
   - First frame-2 output is 0x00/0x10/0x20.
4. sof asserted on pixel (1,2) mid-frame:
   - Counters re-align.
   - The next 8 accepted pixels (including that one) give valid_out=0.
5. rst pulsed for 1 cycle during row 3:
   - Next cycle valid_out=0, eol=0, dout1..3=0.
   - A following full frame reproduces scenario 1 exactly.
6. din = 0xFFFFFF for a whole frame, then 0x000000:
   - Outputs are bit-exact 0xFFFFFF and 0x000000.
   - Second-frame outputs contain no 0xFFFFFF.
